// File: rtl/aging_scan_ctrl.sv
// Time-multiplexes one aging sensor across CH_NUM critical paths and reports
// the peak sensor reading of each enabled channel over a valid/ready port.
module aging_scan_ctrl #(
  parameter int CH_NUM = 4,
  parameter int WIN_W  = 4,
  parameter int SETTLE = 2,
  parameter int DWELL  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cont,
  input  logic                      stop,
  input  logic [CH_NUM-1:0]         chan_mask,
  input  logic [WIN_W-1:0]          threshold,
  input  logic [CH_NUM-1:0]         monitor_in,
  output logic                      sel_monitor,
  output logic                      sensor_clr,
  input  logic [WIN_W-1:0]          aging_signal,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(CH_NUM)-1:0] res_chan,
  output logic [WIN_W-1:0]          res_data,
  output logic                      res_alarm,
  output logic [CH_NUM-1:0]         alarm_flags,
  output logic                      busy,
  output logic                      done
);

  localparam int CW    = $clog2(CH_NUM);
  localparam int CMAX  = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cur_chan, chan_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CH_NUM-1:0]   mask_q;
  logic [WIN_W-1:0]    peak, peak_new;
  logic                done_n;
  logic                has_next;
  logic [CW-1:0]       next_chan;
  logic                last_settle, last_dwell;
  logic                handshake;

  function automatic logic [CW-1:0] lowest_bit(input logic [CH_NUM-1:0] m);
    lowest_bit = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = CW'(i);
    end
  endfunction

  // Lowest enabled channel strictly above the current one, if any.
  always_comb begin
    has_next  = 1'b0;
    next_chan = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask_q[i] && (CW'(i) > cur_chan)) begin
        has_next  = 1'b1;
        next_chan = CW'(i);
      end
    end
  end

  assign last_settle = (cnt == CNT_W'(SETTLE - 1));
  assign last_dwell  = (cnt == CNT_W'(DWELL - 1));
  assign handshake   = (state == S_REPORT) && res_ready;
  assign peak_new    = (aging_signal > peak) ? aging_signal : peak;

  always_comb begin
    state_n = state;
    chan_n  = cur_chan;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (chan_mask != '0) begin
              state_n = S_SETTLE;
              chan_n  = lowest_bit(chan_mask);
              cnt_n   = '0;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (last_settle) begin
            state_n = S_MEASURE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (last_dwell) begin
            state_n = S_REPORT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            cnt_n = '0;
            if (has_next) begin
              state_n = S_SETTLE;
              chan_n  = next_chan;
            end else begin
              done_n = 1'b1;
              if (cont) begin
                state_n = S_SETTLE;
                chan_n  = lowest_bit(mask_q);
              end else begin
                state_n = S_IDLE;
              end
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_chan <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_chan <= chan_n;
      cnt      <= cnt_n;
      done     <= done_n;
    end
  end

  // Peak tracking, result latch, captured mask and sticky alarm flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak        <= '0;
      mask_q      <= '0;
      res_chan    <= '0;
      res_data    <= '0;
      res_alarm   <= 1'b0;
      alarm_flags <= '0;
    end else begin
      if (state == S_SETTLE) begin
        peak <= '0;
      end else if (state == S_MEASURE) begin
        peak <= peak_new;
      end
      if ((state == S_IDLE) && start && !stop && (chan_mask != '0)) begin
        mask_q      <= chan_mask;
        alarm_flags <= '0;
      end
      if ((state == S_MEASURE) && last_dwell && !stop) begin
        res_chan  <= cur_chan;
        res_data  <= peak_new;
        res_alarm <= (threshold != '0) && (peak_new >= threshold);
      end
      if (handshake && !stop && res_alarm) begin
        alarm_flags[res_chan] <= 1'b1;
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign res_valid   = (state == S_REPORT);
  assign sensor_clr  = (state == S_SETTLE) && (cnt == '0);
  assign sel_monitor = busy ? monitor_in[cur_chan] : 1'b0;

endmodule

// File: tb/tb_aging_scan_ctrl.sv
// Directed self-checking bench for aging_scan_ctrl with a small sensor model;
// expected cycle numbers are hand-derived for SETTLE=2, DWELL=16.
module tb_aging_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, cont = 1'b0, stop = 1'b0, res_ready = 1'b0;
  logic [3:0] chan_mask = '0, threshold = '0, monitor_in = '0;
  logic [3:0] aging_signal;
  logic       sel_monitor, sensor_clr, res_valid, res_alarm, busy, done;
  logic [1:0] res_chan;
  logic [3:0] res_data, alarm_flags;

  int tests_run = 0;
  int tests_failed = 0;

  int         sensor_mode = 0;
  logic [3:0] const_val = '0;
  logic [3:0] ramp = '0;

  int         n_res, n_done, n_clr;
  int         r_cyc[8];
  logic [1:0] r_chan[8];
  logic [3:0] r_data[8];
  logic       r_alm[8];
  int         d_cyc[8];
  int         c_cyc[8];
  logic       busy_log[128];

  aging_scan_ctrl #(.CH_NUM(4), .WIN_W(4), .SETTLE(2), .DWELL(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
    .chan_mask(chan_mask), .threshold(threshold), .monitor_in(monitor_in),
    .sel_monitor(sel_monitor), .sensor_clr(sensor_clr), .aging_signal(aging_signal),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_data(res_data), .res_alarm(res_alarm), .alarm_flags(alarm_flags),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sensor model: mode 0 ramps 0..9 and wraps, restarted by sensor_clr;
  // mode 1 reads 5 while the routed path is high, else 4; mode 2 is constant.
  always @(posedge clk) begin
    if (sensor_clr) ramp <= 4'd0;
    else ramp <= (ramp == 4'd9) ? 4'd0 : ramp + 4'd1;
  end
  assign aging_signal = (sensor_mode == 1) ? (sel_monitor ? 4'd5 : 4'd4) :
                        (sensor_mode == 2) ? const_val : ramp;

  task automatic run_scan(input int ncyc, input int poke_cyc, input logic [3:0] poke_mask);
    n_res = 0; n_done = 0; n_clr = 0;
    for (int i = 0; i < 8; i++) begin
      r_cyc[i] = -1; d_cyc[i] = -1; c_cyc[i] = -1;
      r_chan[i] = '0; r_data[i] = '0; r_alm[i] = 1'b0;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      busy_log[c] = busy;
      if (res_valid) begin
        if (n_res < 8) begin
          r_cyc[n_res] = c; r_chan[n_res] = res_chan;
          r_data[n_res] = res_data; r_alm[n_res] = res_alarm;
        end
        n_res++;
      end
      if (done) begin
        if (n_done < 8) d_cyc[n_done] = c;
        n_done++;
      end
      if (sensor_clr) begin
        if (n_clr < 8) c_cyc[n_clr] = c;
        n_clr++;
      end
      if (c == poke_cyc) begin
        start = 1'b1;
        chan_mask = poke_mask;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    monitor_in = 4'hF;
    #12;
    tests_run++; if ({busy, done, res_valid, sensor_clr, sel_monitor, res_alarm} !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {busy, done, res_valid, sensor_clr, sel_monitor, res_alarm}); end
    tests_run++; if ({res_chan, res_data, alarm_flags} !== 10'b0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", {res_chan, res_data, alarm_flags}); end
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++; if ({sensor_clr, done, busy} !== 3'b0) begin tests_failed++; $display("[TB] FAIL reset_release_c%0d: got %b expected 000", k, {sensor_clr, done, busy}); end
    end
    monitor_in = '0;
  endtask

  task automatic test_ramp_scan();
    chan_mask = 4'b1011; cont = 1'b0; res_ready = 1'b1; threshold = '0; sensor_mode = 0;
    run_scan(70, -1, '0);
    tests_run++; if (c_cyc[0] !== 1 || busy_log[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_start: clr_cyc %0d busy %b expected 1 1", c_cyc[0], busy_log[1]); end
    tests_run++; if (n_res !== 3) begin tests_failed++; $display("[TB] FAIL ramp_count: got %0d expected 3", n_res); end
    tests_run++; if (r_cyc[0] !== 19 || r_cyc[1] !== 38 || r_cyc[2] !== 57) begin tests_failed++; $display("[TB] FAIL ramp_timing: got %0d %0d %0d expected 19 38 57", r_cyc[0], r_cyc[1], r_cyc[2]); end
    tests_run++; if (r_chan[0] !== 2'd0 || r_chan[1] !== 2'd1 || r_chan[2] !== 2'd3) begin tests_failed++; $display("[TB] FAIL ramp_chan: got %0d %0d %0d expected 0 1 3", r_chan[0], r_chan[1], r_chan[2]); end
    tests_run++; if (r_data[0] !== 4'd9 || r_data[1] !== 4'd9 || r_data[2] !== 4'd9) begin tests_failed++; $display("[TB] FAIL ramp_data: got %0d %0d %0d expected 9 9 9", r_data[0], r_data[1], r_data[2]); end
    tests_run++; if (n_done !== 1 || d_cyc[0] !== 58 || busy_log[58] !== 1'b0 || busy_log[57] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ramp_done: n %0d cyc %0d busy58 %b expected 1 58 0", n_done, d_cyc[0], busy_log[58]); end
    tests_run++; if (r_alm[0] !== 1'b0 || alarm_flags !== 4'b0) begin tests_failed++; $display("[TB] FAIL ramp_noalarm: got %b %b expected 0 0000", r_alm[0], alarm_flags); end
  endtask

  task automatic test_alarm();
    chan_mask = 4'b1111; cont = 1'b0; res_ready = 1'b1; threshold = 4'd5;
    sensor_mode = 1; monitor_in = 4'b0010;
    run_scan(90, -1, '0);
    tests_run++; if (n_res !== 4) begin tests_failed++; $display("[TB] FAIL alarm_count: got %0d expected 4", n_res); end
    tests_run++; if ({r_alm[0], r_alm[1], r_alm[2], r_alm[3]} !== 4'b0100) begin tests_failed++; $display("[TB] FAIL alarm_bits: got %b expected 0100", {r_alm[0], r_alm[1], r_alm[2], r_alm[3]}); end
    tests_run++; if ({r_data[0], r_data[1], r_data[2], r_data[3]} !== 16'h4544) begin tests_failed++; $display("[TB] FAIL alarm_data: got %h expected 4544", {r_data[0], r_data[1], r_data[2], r_data[3]}); end
    tests_run++; if (alarm_flags !== 4'b0010) begin tests_failed++; $display("[TB] FAIL alarm_flags: got %b expected 0010", alarm_flags); end
    monitor_in = '0;
  endtask

  task automatic test_backpressure();
    int found;
    chan_mask = 4'b0011; cont = 1'b0; res_ready = 1'b0; threshold = '0;
    sensor_mode = 2; const_val = 4'd7; monitor_in = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 1; c <= 40 && found == 0; c++) begin
      if (res_valid) found = c;
      else @(negedge clk);
    end
    tests_run++; if (found !== 19) begin tests_failed++; $display("[TB] FAIL bp_first_valid: got cycle %0d expected 19", found); end
    for (int k = 0; k < 10; k++) begin
      tests_run++; if ({res_valid, res_chan, res_data} !== {1'b1, 2'd0, 4'd7}) begin tests_failed++; $display("[TB] FAIL bp_hold_c%0d: got %b expected 1_00_0111", k, {res_valid, res_chan, res_data}); end
      if (k < 9) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    tests_run++; if ({sensor_clr, res_valid, sel_monitor, busy} !== 4'b1011) begin tests_failed++; $display("[TB] FAIL bp_next_clr: got %b expected 1011", {sensor_clr, res_valid, sel_monitor, busy}); end
    found = 0;
    for (int c = 1; c <= 40 && found == 0; c++) begin
      if (res_valid) found = c;
      else @(negedge clk);
    end
    tests_run++; if (found !== 19 || res_chan !== 2'd1 || res_data !== 4'd7) begin tests_failed++; $display("[TB] FAIL bp_second: cyc %0d chan %0d data %0d expected 19 1 7", found, res_chan, res_data); end
    @(negedge clk);
    tests_run++; if ({done, busy} !== 2'b10) begin tests_failed++; $display("[TB] FAIL bp_done: got %b expected 10", {done, busy}); end
    monitor_in = '0;
    @(negedge clk);
  endtask

  task automatic test_cont_stop();
    int extra;
    chan_mask = 4'b1000; cont = 1'b1; res_ready = 1'b1; threshold = 4'd2;
    sensor_mode = 2; const_val = 4'd3; monitor_in = 4'b1000;
    run_scan(65, -1, '0);
    tests_run++; if (n_res !== 3 || r_chan[0] !== 2'd3 || r_chan[2] !== 2'd3 || r_data[1] !== 4'd3) begin tests_failed++; $display("[TB] FAIL cont_results: n %0d chan %0d data %0d expected 3 3 3", n_res, r_chan[2], r_data[1]); end
    tests_run++; if (n_done !== 3 || d_cyc[0] !== 20 || d_cyc[1] !== 39 || d_cyc[2] !== 58) begin tests_failed++; $display("[TB] FAIL cont_done: n %0d at %0d %0d %0d expected 3 at 20 39 58", n_done, d_cyc[0], d_cyc[1], d_cyc[2]); end
    tests_run++; if (c_cyc[1] !== 20 || c_cyc[3] !== 58) begin tests_failed++; $display("[TB] FAIL cont_clr: got %0d %0d expected 20 58", c_cyc[1], c_cyc[3]); end
    stop = 1'b1; cont = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    tests_run++; if ({busy, res_valid, done, sel_monitor} !== 4'b0) begin tests_failed++; $display("[TB] FAIL stop_idle: got %b expected 0000", {busy, res_valid, done, sel_monitor}); end
    tests_run++; if (alarm_flags !== 4'b1000) begin tests_failed++; $display("[TB] FAIL stop_flags: got %b expected 1000", alarm_flags); end
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy || res_valid) extra++;
      @(negedge clk);
    end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("[TB] FAIL stop_quiet: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_stop_handshake();
    int found;
    chan_mask = 4'b0001; cont = 1'b0; res_ready = 1'b0; threshold = 4'd2;
    sensor_mode = 2; const_val = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 1; c <= 40 && found == 0; c++) begin
      if (res_valid) found = c;
      else @(negedge clk);
    end
    tests_run++; if (found !== 19 || res_alarm !== 1'b1 || alarm_flags !== 4'b0) begin tests_failed++; $display("[TB] FAIL sh_report: cyc %0d alarm %b flags %b expected 19 1 0000", found, res_alarm, alarm_flags); end
    stop = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    stop = 1'b0; res_ready = 1'b0;
    tests_run++; if ({busy, res_valid, done, alarm_flags} !== 7'b0) begin tests_failed++; $display("[TB] FAIL sh_discard: got %b expected 0000000", {busy, res_valid, done, alarm_flags}); end
  endtask

  task automatic test_zero_mask();
    chan_mask = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if ({done, busy, sensor_clr} !== 3'b100) begin tests_failed++; $display("[TB] FAIL zero_done: got %b expected 100", {done, busy, sensor_clr}); end
    @(negedge clk);
    tests_run++; if ({done, busy} !== 2'b00) begin tests_failed++; $display("[TB] FAIL zero_after: got %b expected 00", {done, busy}); end
    chan_mask = 4'b0001; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    tests_run++; if ({busy, sensor_clr, done} !== 3'b000) begin tests_failed++; $display("[TB] FAIL stop_start: got %b expected 000", {busy, sensor_clr, done}); end
  endtask

  task automatic test_back_to_back();
    chan_mask = 4'b0101; cont = 1'b0; res_ready = 1'b1; threshold = '0;
    sensor_mode = 2; const_val = 4'd6;
    run_scan(60, 5, 4'b0010);
    tests_run++; if (n_res !== 2 || r_chan[0] !== 2'd0 || r_chan[1] !== 2'd2) begin tests_failed++; $display("[TB] FAIL busy_start_order: n %0d chans %0d %0d expected 2 0 2", n_res, r_chan[0], r_chan[1]); end
    tests_run++; if (r_cyc[0] !== 19 || r_cyc[1] !== 38 || r_data[1] !== 4'd6) begin tests_failed++; $display("[TB] FAIL busy_start_timing: %0d %0d data %0d expected 19 38 6", r_cyc[0], r_cyc[1], r_data[1]); end
    tests_run++; if (n_done !== 1 || d_cyc[0] !== 39 || busy_log[39] !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_start_done: n %0d cyc %0d expected 1 39", n_done, d_cyc[0]); end
  endtask

  initial begin
    test_reset();
    test_ramp_scan();
    test_alarm();
    test_backpressure();
    test_cont_stop();
    test_stop_handshake();
    test_zero_mask();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aging_scan_ctrl.md
# aging_scan_ctrl

Time-multiplexes one aging sensor across `CH_NUM` monitored critical-path signals. The controller:
- steps through the enabled channels and routes each channel's path signal into the sensor's `monitor_signal` input;
- clears the sensor, waits for the path to settle, then samples `aging_signal` over a dwell window;
- reports each channel's peak reading through a valid/ready result port.

It sits between the monitored logic, the aging sensor instance and the downstream reporting logic (UART or register bank).

## Interface
Parameters:
- `CH_NUM`, 4: number of monitored channels (2..16).
- `WIN_W`, 4: width of the sensor `aging_signal` bus (the count window).
- `SETTLE`, 2: cycles between a mux switch and the start of sampling (≥1).
- `DWELL`, 16: sampling cycles per channel (≥1).

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- `cont`  in  1  1 = restart the scan after the last channel; 0 = single pass.
- `stop`  in  1  abort; overrides every other input.
- `chan_mask`  in  CH_NUM  per-channel enable; captured at `start`.
- `threshold`  in  WIN_W  alarm level; 0 disables alarms.
- `monitor_in`  in  CH_NUM  path signals to be monitored.
- `sel_monitor`  out  1  drives the sensor `monitor_signal`.
- `sensor_clr`  out  1  one-cycle clear to the sensor counter.
- `aging_signal`  in  WIN_W  sensor output.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_chan`  out  clog2(CH_NUM)  channel index of the result.
- `res_data`  out  WIN_W  peak `aging_signal` seen during the dwell.
- `res_alarm`  out  1  `res_data >= threshold` and `threshold != 0`.
- `alarm_flags`  out  CH_NUM  sticky per-channel alarm flags; cleared on an accepted `start`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.

## Operation
States: IDLE, SETTLE, MEASURE, REPORT.
- **IDLE:**
  - `start=1` with captured mask ≠ 0: `cur_chan` ← lowest set bit, clear `alarm_flags`, go to SETTLE.
  - `start=1` with mask = 0: pulse `done` on the next cycle and stay in IDLE. Nothing is reported.
- **SETTLE:**
  - `sensor_clr=1` in the first SETTLE cycle only.
  - Lasts `SETTLE` cycles, then go to MEASURE. Clear `peak` to 0 on entry.
- **MEASURE:**
  - For `DWELL` cycles: `peak` ← max(`peak`, `aging_signal`), unsigned compare.
  - Then latch `res_chan`, `res_data`, `res_alarm` and go to REPORT.
- **REPORT:**
  - `res_valid=1`. Result outputs stay stable while valid and not ready.
  - On `res_valid & res_ready`: set `alarm_flags[res_chan]` if `res_alarm`, then advance:
    - next higher enabled channel exists: go to SETTLE with that channel;
    - otherwise pulse `done` and wrap: with `cont=1`, go to SETTLE on the lowest enabled channel; with `cont=0`, go to IDLE.
- **Channel mux:** `sel_monitor = monitor_in[cur_chan]` (combinational) in SETTLE, MEASURE and REPORT; 0 in IDLE.
- **`stop`:** in any state, forces IDLE on the next edge. It drops `res_valid` without a transfer, does not pulse `done`, and keeps `alarm_flags`.
- **Other inputs:**
  - `chan_mask` changes during a scan are ignored until the next `start` (`cont` wraps reuse the captured mask).
  - `start` while busy is ignored.
  - `threshold` is sampled at the MEASURE→REPORT transition.
- **Width rule:** `peak` is WIN_W bits and saturates naturally at the maximum value; there is no overflow.

## Timing
- **Reset values:** all outputs 0, state IDLE, `cur_chan` 0, `peak` 0.
- **Start:** `start` asserted at edge N gives `busy=1` and `sensor_clr=1` from cycle N+1.
- **First-result latency:** 1 + SETTLE + DWELL cycles from `start` to `res_valid` (19 with defaults).
- **Channel-to-channel period:** SETTLE + DWELL + 1 cycles with `res_ready` tied high; each extra cycle of `res_ready` low adds one cycle.
- **`done`:**
  - Asserted in the cycle after the final handshake.
  - With `cont=1` it coincides with `sensor_clr` for the wrapped channel.
  - `busy` falls in the same cycle as `done` when `cont=0`.
- **`alarm_flags`:** updated on the cycle after the handshake.
- **Simultaneous events:**
  - `stop` and `start` together in IDLE: stay in IDLE.
  - `stop` during a REPORT handshake: the transfer is discarded and the flag is not set.

## Test plan
- Reset with inputs idle → every output 0; release `rst_n` asynchronously mid-cycle → no spurious `sensor_clr` or `done`.
- `chan_mask=4'b1011`, `cont=0`, `res_ready=1`, `aging_signal` ramping 0..9 within each dwell → three results with `res_chan` 0, 1, 3 and `res_data=9` each; `done` after channel 3; first `res_valid` 19 cycles after `start`.
- `threshold=5`, sensor held at 5 on channel 1 and 4 elsewhere, mask `4'b1111` → only channel 1 reports `res_alarm=1`; `alarm_flags=4'b0010`.
- `res_ready` held low 10 cycles in REPORT → `res_valid`, `res_chan`, `res_data` stable for all 10 cycles; next `sensor_clr` appears exactly 1 cycle after the handshake.
- `cont=1`, mask `4'b1000` → continuous channel-3 results, `done` every 19 cycles; assert `stop` mid-MEASURE → IDLE next cycle, `res_valid=0`, no `done`.
- `start` with mask 0 → `done` pulse 1 cycle later, `busy` stays 0; `start` pulsed while busy → scan order unchanged.
